div_arbiter: RTL

Round-robin scheduler that shares one `pipelinediv` instance (fixed-latency, fully pipelined, one new operation per clock) among NREQ requesters. It arbitrates operand requests and drives the divider's input ports. A tag shift register tracks every in-flight operation, so each result is returned with the ID of its requester. Divide-by-zero is detected at issue and reported with the result. Sits between client blocks and the divider; the divider itself is instantiated beside it, not inside it.

---
 rtl/div_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end for a shared fixed-latency pipelined divider.
// Tags each issued operation so results return with requester id and divide-by-zero flag.
module div_arbiter #(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8,
  parameter int NREQ     = 4,
  parameter int LATENCY  = 16,
  parameter int MAXOUT   = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*DIVIDEND-1:0]     req_dividend,
  input  logic [NREQ*DIVISOR-1:0]      req_divisor,
  output logic [DIVIDEND-1:0]          div_dividend,
  output logic [DIVISOR-1:0]           div_divisor,
  input  logic [DIVIDEND-1:0]          div_quotient,
  input  logic [DIVISOR-1:0]           div_remainder,
  output logic                         rsp_valid,
  output logic [$clog2(NREQ)-1:0]      rsp_id,
  output logic [DIVIDEND-1:0]          rsp_quotient,
  output logic [DIVISOR-1:0]           rsp_remainder,
  output logic                         rsp_dbz
);

  localparam int IW   = $clog2(NREQ);
  localparam int CW   = $clog2(MAXOUT + 1);
  localparam int LAST = LATENCY;
  localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);
  localparam logic [CW-1:0] MAXOUT_W = CW'(MAXOUT);
  localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

  logic [IW-1:0]       last_grant;
  logic [CW-1:0]       outstanding [NREQ];
  logic [LAST:0]       tag_vld;
  logic [LAST:0]       tag_dbz;
  logic [IW-1:0]       tag_id [LAST+1];

  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     dec_hit;
  logic                grant_any;
  logic [IW-1:0]       grant_idx;
  logic [IW:0]         cand;
  logic [DIVIDEND-1:0] sel_dividend;
  logic [DIVISOR-1:0]  sel_divisor;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = reset_n && req_valid[i] && (outstanding[i] < MAXOUT_W);
    end
  end

  // Search starts one past the last winner and wraps, so each requester waits at most NREQ-1 grants.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_any && eligible[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    req_ready    = '0;
    dec_hit      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_dividend = req_dividend[i*DIVIDEND +: DIVIDEND];
        sel_divisor  = req_divisor[i*DIVISOR +: DIVISOR];
      end
      req_ready[i] = grant_any && (grant_idx == IW'(i));
      dec_hit[i]   = tag_vld[LAST] && (tag_id[LAST] == IW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant    <= LAST_REQ;
      div_dividend  <= '0;
      div_divisor   <= '0;
      tag_vld       <= '0;
      tag_dbz       <= '0;
      for (int k = 0; k <= LAST; k++) tag_id[k] <= '0;
      for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
    end else begin
      // Bubbles enter the tag pipe on idle cycles so it stays aligned with the divider.
      tag_vld   <= {tag_vld[LAST-1:0], grant_any};
      tag_dbz   <= {tag_dbz[LAST-1:0], grant_any && (sel_divisor == '0)};
      tag_id[0] <= grant_idx;
      for (int k = LAST; k > 0; k--) tag_id[k] <= tag_id[k-1];

      if (grant_any) begin
        last_grant   <= grant_idx;
        div_dividend <= sel_dividend;
        div_divisor  <= sel_divisor;
      end

      rsp_valid <= tag_vld[LAST];
      if (tag_vld[LAST]) begin
        rsp_id  <= tag_id[LAST];
        rsp_dbz <= tag_dbz[LAST];
        if (tag_dbz[LAST]) begin
          rsp_quotient  <= '1;
          rsp_remainder <= '0;
        end else begin
          rsp_quotient  <= div_quotient;
          rsp_remainder <= div_remainder;
        end
      end

      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && !dec_hit[i]) begin
          outstanding[i] <= outstanding[i] + CW'(1);
        end else if (!req_ready[i] && dec_hit[i] && (outstanding[i] != '0)) begin
          outstanding[i] <= outstanding[i] - CW'(1);
        end
      end
    end
  end

endmodule
